// File: rtl/ram_scan_reader_if.sv
// Bundle of the scan reader's control, RAM read port and display-side signals.
// The reader uses the slave view; the board top or a bench drives through master.
interface ram_scan_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
);
  logic              run_i;
  logic              step_i;
  logic [DATA_W-1:0] ram_q_i;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [ADDR_W-1:0] disp_addr_o;
  logic [DATA_W-1:0] disp_data_o;
  logic              valid_o;
  logic              wrap_o;

  modport slave (
    input  run_i, step_i, ram_q_i,
    output rd_addr_o, disp_addr_o, disp_data_o, valid_o, wrap_o
  );

  modport master (
    output run_i, step_i, ram_q_i,
    input  rd_addr_o, disp_addr_o, disp_data_o, valid_o, wrap_o
  );
endinterface

// File: rtl/ram_scan_reader.sv
// Read-side master for the on-board RAM: walks the address space and holds each
// {address, data} pair on the display for DWELL clocks, in auto-scan or single-step mode.
module ram_scan_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1,
  parameter int DWELL  = 50_000_000
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  ram_scan_reader_if.slave bus
);

  localparam int DW_W = (DWELL  > 1) ? $clog2(DWELL)  : 1;
  localparam int LT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [DW_W-1:0]   DWELL_ONE  = DW_W'(1);
  localparam logic [LT_W-1:0]   LAT_LAST   = LT_W'(RD_LAT - 1);
  localparam logic [LT_W-1:0]   LAT_ONE    = LT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    PAUSE
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] disp_addr_q;
  logic [DATA_W-1:0] disp_data_q;
  logic              valid_q;
  logic              wrap_q;
  logic [DW_W-1:0]   dwell_q;
  logic [LT_W-1:0]   lat_q;

  // wrap_q defaults low every clock so it only ever lasts the one clock after an increment
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      disp_addr_q <= '0;
      disp_data_q <= '0;
      valid_q     <= 1'b0;
      wrap_q      <= 1'b0;
      dwell_q     <= '0;
      lat_q       <= '0;
    end else begin
      wrap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.run_i || bus.step_i) begin
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          lat_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (lat_q == LAT_LAST) begin
            disp_data_q <= bus.ram_q_i;
            disp_addr_q <= rd_addr_q;
            valid_q     <= 1'b1;
            dwell_q     <= '0;
            state_q     <= HOLD;
          end else begin
            lat_q <= lat_q + LAT_ONE;
          end
        end
        HOLD: begin
          if (dwell_q == DWELL_LAST) begin
            if (bus.run_i) begin
              rd_addr_q <= rd_addr_q + ADDR_ONE;
              wrap_q    <= (rd_addr_q == ADDR_MAX);
              state_q   <= ISSUE;
            end else begin
              state_q <= PAUSE;
            end
          end else begin
            dwell_q <= dwell_q + DWELL_ONE;
          end
        end
        PAUSE: begin
          // run and step together still give just one advance
          if (bus.run_i || bus.step_i) begin
            rd_addr_q <= rd_addr_q + ADDR_ONE;
            wrap_q    <= (rd_addr_q == ADDR_MAX);
            state_q   <= ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rd_addr_o   = rd_addr_q;
  assign bus.disp_addr_o = disp_addr_q;
  assign bus.disp_data_o = disp_data_q;
  assign bus.valid_o     = valid_q;
  assign bus.wrap_o      = wrap_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Randomised scoreboard bench for ram_scan_reader: a timing-level model predicts each
// displayed word and its capture edge; a negedge monitor compares what the reader shows.
module tb_ram_scan_reader;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int RD_LAT = 1;
  localparam int DWELL  = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct {
    int addr;
    int data;
    int edgeNo;
  } cap_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  cap_t expQ[$];
  int   edgeCount    = 0;
  int   wrapEdge     = -1;
  int   firstCapEdge = 0;
  int   phase        = 0;
  int   curAddr      = 0;
  bit   started      = 1'b0;
  bit   paused       = 1'b0;
  int   vectors      = 0;
  int   miscompares  = 0;

  logic [ADDR_W-1:0] prevAddr  = '0;
  logic [DATA_W-1:0] prevData  = '0;
  logic              prevValid = 1'b0;

  ram_scan_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_scan_reader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT),
    .DWELL (DWELL)
  ) dut (
    .clk_i   (clk),
    .resetn_i(resetn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] ramWord(input int a);
    logic [31:0] v;
    v = a;
    return v[3:0] ^ 4'hA;
  endfunction

  // One-cycle-latency synchronous RAM preloaded with mem[a] = a[3:0] ^ 4'hA
  always @(posedge clk) bus.ram_q_i <= ramWord(int'(bus.rd_addr_o));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edgeCount);
    end
  endtask

  task automatic advanceModel(input bit first);
    if (!first) begin
      curAddr = (curAddr + 1) % DEPTH;
      if (curAddr == 0) wrapEdge = edgeCount;
    end
    phase  = 0;
    paused = 1'b0;
    expQ.push_back(cap_t'{curAddr, int'(ramWord(curAddr)), edgeCount + 1 + RD_LAT});
  endtask

  // Each word: 1 issue + RD_LAT wait clocks to capture, then DWELL clocks on display
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      started  = 1'b0;
      paused   = 1'b0;
      phase    = 0;
      curAddr  = 0;
      wrapEdge = -1;
      expQ.delete();
    end else begin
      edgeCount++;
      if (!started) begin
        if (bus.run_i || bus.step_i) begin
          started      = 1'b1;
          firstCapEdge = edgeCount + 1 + RD_LAT;
          advanceModel(1'b1);
        end
      end else if (paused) begin
        if (bus.run_i || bus.step_i) advanceModel(1'b0);
      end else begin
        phase++;
        if (phase == 1 + RD_LAT + DWELL) begin
          if (bus.run_i) advanceModel(1'b0);
          else paused = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit capSeen;
    bit capDue;
    if (!resetn) begin
      prevAddr  = '0;
      prevData  = '0;
      prevValid = 1'b0;
    end else begin
      capSeen = (bus.valid_o && !prevValid) || (bus.disp_addr_o != prevAddr);
      capDue  = (expQ.size() > 0) && (expQ[0].edgeNo == edgeCount);
      checkOutput("captureTiming", 32'(capSeen), 32'(capDue));
      if (capDue) begin
        checkOutput("dispAddr", 32'(bus.disp_addr_o), expQ[0].addr);
        checkOutput("dispData", 32'(bus.disp_data_o), expQ[0].data);
        void'(expQ.pop_front());
      end else begin
        checkOutput("dispDataStable", 32'(bus.disp_data_o), 32'(prevData));
      end
      checkOutput("valid", 32'(bus.valid_o), 32'(started && (edgeCount >= firstCapEdge)));
      checkOutput("wrap", 32'(bus.wrap_o), 32'(edgeCount == wrapEdge));
      checkOutput("rdAddr", 32'(bus.rd_addr_o), curAddr);
      prevAddr  = bus.disp_addr_o;
      prevData  = bus.disp_data_o;
      prevValid = bus.valid_o;
    end
  end

  task automatic applyStimulus(input bit runIn, input bit stepIn, input int cycles);
    bus.run_i  = runIn;
    bus.step_i = stepIn;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int  budget;
    bit  runNow;
    bus.run_i  = 1'b0;
    bus.step_i = 1'b0;
    resetn     = 1'b0;
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);

    $display("[TB] idle after reset");
    applyStimulus(1'b0, 1'b0, 20);

    $display("[TB] auto-scan through wrap, stray steps");
    for (int i = 0; i < 210; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1);

    $display("[TB] drop run mid-dwell at address 5, then single steps");
    budget = 400;
    while (!(started && !paused && curAddr == 5 && phase == 3) && budget > 0) begin
      applyStimulus(1'b1, 1'b0, 1);
      budget--;
    end
    checkOutput("reachAddr5", 32'(budget > 0), 32'd1);
    applyStimulus(1'b0, 1'b0, 20);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 20);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 20);

    $display("[TB] steps in busy states, run+step together in pause");
    applyStimulus(1'b0, 1'b1, 5);
    applyStimulus(1'b0, 1'b0, 20);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 20);

    $display("[TB] random run/step traffic");
    runNow = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) runNow = ~runNow;
      applyStimulus(runNow, 1'($urandom_range(0, 7) == 0), 1);
    end

    $display("[TB] reset during read of address 9");
    budget = 400;
    while (!(started && !paused && curAddr == 9 && phase == 0) && budget > 0) begin
      applyStimulus(1'b1, 1'b0, 1);
      budget--;
    end
    checkOutput("reachAddr9", 32'(budget > 0), 32'd1);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checkOutput("resetRdAddr", 32'(bus.rd_addr_o), 32'd0);
    checkOutput("resetDispAddr", 32'(bus.disp_addr_o), 32'd0);
    checkOutput("resetDispData", 32'(bus.disp_data_o), 32'd0);
    checkOutput("resetValid", 32'(bus.valid_o), 32'd0);
    checkOutput("resetWrap", 32'(bus.wrap_o), 32'd0);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
